// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: stage state
// encoding, the default PC value used for bubbles, and a helper that maps
// the stage state onto the occupancy count.
package pipe_pkg;

    // Number of entries currently held by the stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // PC value carried by a bubble (PC+8 convention of the upstream core).
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Occupancy count presented for a given state.
    function automatic logic [1:0] state_occupancy(input stage_state_t st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_HALF:  occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: DATA_W payload bits plus a 32-bit PC field.
// Clear turns the entry into a bubble (payload 0, PC = PC_RESET) and wins
// over load; the asynchronous reset produces the same bubble.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [31:0]       i_pc,
    output logic [DATA_W-1:0] o_data,
    output logic [31:0]       o_pc
);

    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_pc;

    // Entry storage: bubble on reset or clear, capture on load, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= {DATA_W{1'b0}};
            r_pc   <= PC_RESET;
        end else if (i_clear) begin
            r_data <= {DATA_W{1'b0}};
            r_pc   <= PC_RESET;
        end else if (i_load) begin
            r_data <= i_data;
            r_pc   <= i_pc;
        end else begin
            r_data <= r_data;
            r_pc   <= r_pc;
        end
    end

    assign o_data = r_data;
    assign o_pc   = r_pc;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshakes on both sides.
// Build option PIPE_STAGE_SKID_EN:
//   defined   - two entries (head + skid); in_ready comes from a register,
//               so there is no combinational path from out_ready.
//   undefined - single head entry; in_ready = !out_valid | out_ready,
//               which is combinational through out_ready.
// The head entry always drives out_data/out_pc; an empty stage shows a
// bubble (data 0, PC = PC_RESET). flush empties the stage and beats any
// transfer that coincides with it.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [1:0]        occupancy
);

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic              r_out_valid;
    logic [1:0]        r_occupancy;

    logic              w_it;
    logic              w_ot;
    logic              w_head_load;
    logic              w_head_clear;
    logic [DATA_W-1:0] w_head_din;
    logic [31:0]       w_head_pc_din;
    logic [DATA_W-1:0] w_head_data;
    logic [31:0]       w_head_pc;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_in_ready;
    logic              w_head_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [DATA_W-1:0] w_skid_data;
    logic [31:0]       w_skid_pc;

    // Upstream may push whenever the skid slot is free; registered flag only.
    assign in_ready = r_in_ready;
`else
    // Single entry: accept when empty or when the held entry leaves now.
    assign in_ready = ~r_out_valid | out_ready;
`endif

    assign w_it = in_valid & in_ready;
    assign w_ot = r_out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    // Next-state and entry-control decode for the two-entry stage.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_load      = 1'b0;
        w_head_clear     = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_it) begin
                        w_head_load = 1'b1;
                        w_state_nxt = ST_HALF;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (w_it && w_ot) begin
                        w_head_load = 1'b1;
                        w_state_nxt = ST_HALF;
                    end else if (w_it) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_ot) begin
                        w_head_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_HALF;
                    end
                end
                ST_FULL: begin
                    if (w_ot) begin
                        w_head_load      = 1'b1;
                        w_head_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = ST_HALF;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt  = ST_EMPTY;
                    w_head_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Head refills from the skid slot when draining FULL, else from upstream.
    always_comb begin
        if (w_head_from_skid) begin
            w_head_din    = w_skid_data;
            w_head_pc_din = w_skid_pc;
        end else begin
            w_head_din    = in_data;
            w_head_pc_din = in_pc;
        end
    end
`else
    // Next-state and entry-control decode for the single-entry stage.
    always_comb begin
        w_state_nxt  = r_state;
        w_head_load  = 1'b0;
        w_head_clear = 1'b0;
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_head_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_it) begin
                        w_head_load = 1'b1;
                        w_state_nxt = ST_HALF;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (w_it) begin
                        w_head_load = 1'b1;
                        w_state_nxt = ST_HALF;
                    end else if (w_ot) begin
                        w_head_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_HALF;
                    end
                end
                default: begin
                    w_state_nxt  = ST_EMPTY;
                    w_head_clear = 1'b1;
                end
            endcase
        end
    end

    // Only upstream can feed the single head entry.
    always_comb begin
        w_head_din    = in_data;
        w_head_pc_din = in_pc;
    end
`endif

    // State register with registered status outputs derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
            r_in_ready  <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_occupancy <= state_occupancy(w_state_nxt);
`ifdef PIPE_STAGE_SKID_EN
            r_in_ready  <= (w_state_nxt != ST_FULL);
`endif
        end
    end

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_RESET (PC_RESET)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_data  (w_head_din),
        .i_pc    (w_head_pc_din),
        .o_data  (w_head_data),
        .o_pc    (w_head_pc)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_RESET (PC_RESET)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_pc    (in_pc),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc)
    );
`endif

    assign out_valid = r_out_valid;
    assign occupancy = r_occupancy;
    assign out_data  = w_head_data;
    assign out_pc    = w_head_pc;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. The reference model is a plain
// queue of accepted entries with a capacity of 2 (skid build) or 1.
module tb_pipe_stage_skid;

    localparam int          DATA_W = 64;
    localparam logic [31:0] PC_RST = 32'h0000_3000;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP    = 2;
`else
    localparam int          CAP    = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [31:0]       pc;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic [1:0]        occupancy;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .PC_RESET(PC_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Model expectations derived from the queue contents.
    function automatic logic m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction
    function automatic logic m_valid();
        return q.size() > 0;
    endfunction
    function automatic logic [DATA_W-1:0] m_data();
        logic [DATA_W-1:0] z = '0;
        return (q.size() > 0) ? q[0].d : z;
    endfunction
    function automatic logic [31:0] m_pc();
        return (q.size() > 0) ? q[0].pc : PC_RST;
    endfunction
    function automatic logic [1:0] m_occ();
        return 2'(q.size());
    endfunction

    // Advance one clock: apply the handshake rules to the model at the edge.
    task automatic tick();
        bit   it;
        bit   ot;
        ent_t e;
        it     = in_valid && m_in_ready();
        ot     = (q.size() > 0) && out_ready;
        e.d    = in_data;
        e.pc   = in_pc;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (ot) void'(q.pop_front());
            if (it) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        q.delete();
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        n_checks++; if (occupancy !== 2'd0) begin n_errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_data !== 64'h0) begin n_errors++; $display("FAIL rst_data got=%h exp=0", out_data); end
        n_checks++; if (out_pc !== PC_RST) begin n_errors++; $display("FAIL rst_pc got=%h exp=%h", out_pc, PC_RST); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] pc_s;
        idle_inputs();
        in_valid = 1'b1; in_data = 64'hA5; in_pc = $urandom; out_ready = 1'b1;
        pc_s = in_pc;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_data !== 64'hA5) begin n_errors++; $display("FAIL basic_data got=%h exp=a5", out_data); end
        n_checks++; if (occupancy !== 2'd1) begin n_errors++; $display("FAIL basic_occ got=%0d exp=1", occupancy); end
        n_checks++; if (out_pc !== pc_s) begin n_errors++; $display("FAIL basic_pc got=%h exp=%h", out_pc, pc_s); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
        tick();
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_fill_drain();
        idle_inputs();
        in_valid = 1'b1; in_data = 64'h11; in_pc = 32'h100;
        #1; tick();
        in_data = 64'h22; in_pc = 32'h104;
        #1; tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (occupancy !== 2'd2) begin n_errors++; $display("FAIL fill_occ got=%0d exp=2", occupancy); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_data !== 64'h11) begin n_errors++; $display("FAIL fill_head got=%h exp=11", out_data); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready_path got=%b exp=0", in_ready); end
        tick(); #1;
        n_checks++; if (out_data !== 64'h22) begin n_errors++; $display("FAIL drain_second got=%h exp=22", out_data); end
        n_checks++; if (out_pc !== 32'h104) begin n_errors++; $display("FAIL drain_pc got=%h exp=104", out_pc); end
        tick(); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
        tick();
    endtask
`else
    task automatic test_single_entry();
        idle_inputs();
        in_valid = 1'b1; in_data = 64'h11; in_pc = 32'h100;
        #1; tick();
        in_data = 64'h22; in_pc = 32'h104;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL single_in_ready got=%b exp=0", in_ready); end
        tick(); #1;
        n_checks++; if (occupancy !== 2'd1) begin n_errors++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
        n_checks++; if (out_data !== 64'h11) begin n_errors++; $display("FAIL single_hold got=%h exp=11", out_data); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL single_comb_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_data !== 64'h22) begin n_errors++; $display("FAIL single_next got=%h exp=22", out_data); end
        tick(); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
        tick();
    endtask
`endif

    task automatic test_simultaneous();
        idle_inputs();
        in_valid = 1'b1; in_data = 64'h33; in_pc = 32'h200;
        #1; tick();
        in_data = 64'h44; in_pc = 32'h204; out_ready = 1'b1;
        #1; tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (occupancy !== 2'd1) begin n_errors++; $display("FAIL simul_occ got=%0d exp=1", occupancy); end
        n_checks++; if (out_data !== 64'h44) begin n_errors++; $display("FAIL simul_data got=%h exp=44", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < CAP; i++) begin
            in_valid = 1'b1; in_data = 64'h50 + 64'(i); in_pc = 32'h300 + 32'(4 * i);
            #1; tick();
        end
        in_valid = 1'b1; in_data = 64'hDEAD; in_pc = 32'h3F0; flush = 1'b1;
        #1; tick();
        in_valid = 1'b0; flush = 1'b0;
        #1;
        n_checks++; if (occupancy !== 2'd0) begin n_errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        n_checks++; if (out_data !== 64'h0) begin n_errors++; $display("FAIL flush_data got=%h exp=0", out_data); end
        n_checks++; if (out_pc !== PC_RST) begin n_errors++; $display("FAIL flush_pc got=%h exp=%h", out_pc, PC_RST); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        // Accepted-looking input on an empty stage is still discarded by flush.
        in_valid = 1'b1; in_data = 64'hBEEF; flush = 1'b1; out_ready = 1'b1;
        #1; tick();
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_discard cyc=%0d got=%b exp=0", i, out_valid); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        for (int i = 0; i < CAP; i++) begin
            in_valid = 1'b1; in_data = 64'h60 + 64'(i); in_pc = 32'h400 + 32'(4 * i);
            #1; tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (occupancy !== m_occ()) begin n_errors++; $display("FAIL areset_pre got=%0d exp=%0d", occupancy, m_occ()); end
        #1 reset = 1'b1;
        #1;
        q.delete();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        n_checks++; if (occupancy !== 2'd0) begin n_errors++; $display("FAIL areset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h77; in_pc = 32'h500;
        #1; tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (occupancy !== 2'd1) begin n_errors++; $display("FAIL areset_after_occ got=%0d exp=1", occupancy); end
        n_checks++; if (out_data !== 64'h77) begin n_errors++; $display("FAIL areset_after_data got=%h exp=77", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = {$urandom, $urandom};
            in_pc     = $urandom;
            #1;
            n_checks++; if (in_ready !== m_in_ready()) begin n_errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_in_ready()); end
            n_checks++; if (out_valid !== m_valid()) begin n_errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m_valid()); end
            n_checks++; if (out_data !== m_data()) begin n_errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, m_data()); end
            n_checks++; if (out_pc !== m_pc()) begin n_errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, out_pc, m_pc()); end
            n_checks++; if (occupancy !== m_occ()) begin n_errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_occ()); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef PIPE_STAGE_SKID_EN
        test_fill_drain();
`else
        test_single_entry();
`endif
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
